// File: rtl/oddr_pattern_gen_if.sv
// rtl/oddr_pattern_gen_if.sv - control and ODDR beat signals of the pattern generator
interface oddr_pattern_gen_if #(
  parameter int LEN_W = 16
);
  logic             enable;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] burst_len;
  logic             d_rise;
  logic             d_fall;
  logic             oe;
  logic             busy;
  logic             done;

  modport master (
    output enable, start, mode, burst_len,
    input  d_rise, d_fall, oe, busy, done
  );

  modport slave (
    input  enable, start, mode, burst_len,
    output d_rise, d_fall, oe, busy, done
  );
endinterface

// File: rtl/oddr_pattern_gen.sv
// rtl/oddr_pattern_gen.sv - registered (d_rise, d_fall, oe) burst source for one ODDR pin
module oddr_pattern_gen #(
  parameter logic [6:0] PRBS_SEED  = 7'h7F,
  parameter int         LEN_W      = 16,
  parameter logic       IDLE_LEVEL = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  oddr_pattern_gen_if.slave pg
);

  localparam logic [6:0] SEED_EFF = (PRBS_SEED == 7'h00) ? 7'h01 : PRBS_SEED;

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic             tog_q, tog_d;
  logic             d_rise_q, d_rise_d;
  logic             d_fall_q, d_fall_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       beat_mode;
  logic [6:0]       beat_lfsr;
  logic             beat_tog;
  logic [8:0]       prbs;
  logic [1:0]       beat;
  logic             emit;

  // Two x^7+x^6+1 steps: {first out, second out, state after both steps}
  function automatic logic [8:0] prbs_beat(input logic [6:0] s);
    logic [6:0] s1;
    logic [6:0] s2;
    s1 = {s[5:0], s[6] ^ s[5]};
    s2 = {s1[5:0], s1[6] ^ s1[5]};
    return {s[6], s1[6], s2};
  endfunction

  // In IDLE the first beat is built from the live inputs so it lands on the start edge
  always_comb begin
    beat_mode = mode_q;
    beat_lfsr = lfsr_q;
    beat_tog  = tog_q;
    if (state_q == ST_IDLE) begin
      beat_mode = pg.mode;
      beat_lfsr = SEED_EFF;
      beat_tog  = 1'b1;
    end
    prbs = prbs_beat(beat_lfsr);
    case (beat_mode)
      2'b00:   beat = 2'b10;
      2'b01:   beat = 2'b01;
      2'b10:   beat = {beat_tog, beat_tog};
      default: beat = prbs[8:7];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    tog_d    = tog_q;
    d_rise_d = IDLE_LEVEL;
    d_fall_d = IDLE_LEVEL;
    oe_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    emit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pg.start && pg.enable) begin
          state_d = ST_RUN;
          mode_d  = pg.mode;
          len_d   = pg.burst_len;
          cnt_d   = LEN_W'(1);
          emit    = 1'b1;
        end
      end
      default: begin
        if (!pg.enable) begin
          state_d = ST_IDLE;
        end else if ((len_q != '0) && (cnt_q == len_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
          emit  = 1'b1;
        end
      end
    endcase
    if (emit) begin
      d_rise_d = beat[1];
      d_fall_d = beat[0];
      oe_d     = 1'b1;
      busy_d   = 1'b1;
      lfsr_d   = prbs[6:0];
      tog_d    = ~beat_tog;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'b00;
      len_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      tog_q    <= 1'b1;
      d_rise_q <= IDLE_LEVEL;
      d_fall_q <= IDLE_LEVEL;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      tog_q    <= tog_d;
      d_rise_q <= d_rise_d;
      d_fall_q <= d_fall_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pg.d_rise = d_rise_q;
  assign pg.d_fall = d_fall_q;
  assign pg.oe     = oe_q;
  assign pg.busy   = busy_q;
  assign pg.done   = done_q;

endmodule
